// File: rtl/jtcop_gfx_romarb.sv
// Graphics ROM responder: four request/acknowledge ROM slots, each with a
// one-entry cache, served from one shared 32-bit memory port. Slots are
// granted round-robin and only one memory transaction is outstanding.
module jtcop_gfx_romarb #(
    parameter logic [21:0] OFFSET0 = 22'h00000,
    parameter logic [21:0] OFFSET1 = 22'h40000,
    parameter logic [21:0] OFFSET2 = 22'h80000,
    parameter logic [21:0] OFFSET3 = 22'hC0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic        slot0_cs,
    input  logic [17:0] slot0_addr,
    output logic [31:0] slot0_data,
    output logic        slot0_ok,
    input  logic        slot1_cs,
    input  logic [17:0] slot1_addr,
    output logic [31:0] slot1_data,
    output logic        slot1_ok,
    input  logic        slot2_cs,
    input  logic [17:0] slot2_addr,
    output logic [31:0] slot2_data,
    output logic        slot2_ok,
    input  logic        slot3_cs,
    input  logic [17:0] slot3_addr,
    output logic [31:0] slot3_data,
    output logic        slot3_ok,
    output logic        mem_req,
    output logic [21:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rdy,
    input  logic [31:0] mem_data
);
    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_DATA} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cs_vec;
    logic [17:0] addr_arr [4];
    logic [21:0] offset_arr [4];
    logic [3:0]  ok_vec;
    logic [3:0]  pending;
    logic        valid_reg [4];
    logic [17:0] tag_reg [4];
    logic [31:0] dat_reg [4];
    logic [1:0]  last_reg, last_next;
    logic [1:0]  sel_reg, sel_next;
    logic [17:0] req_tag_reg, req_tag_next;
    logic        mem_req_reg, mem_req_next;
    logic [21:0] mem_addr_reg, mem_addr_next;
    logic        fill;
    logic        win_found;
    logic [1:0]  win_idx;

    assign cs_vec        = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
    assign addr_arr[0]   = slot0_addr;
    assign addr_arr[1]   = slot1_addr;
    assign addr_arr[2]   = slot2_addr;
    assign addr_arr[3]   = slot3_addr;
    assign offset_arr[0] = OFFSET0;
    assign offset_arr[1] = OFFSET1;
    assign offset_arr[2] = OFFSET2;
    assign offset_arr[3] = OFFSET3;

    // Hit is purely combinational so a matching address is acknowledged
    // in the same cycle it is presented.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign ok_vec[gi]  = cs_vec[gi] & valid_reg[gi] &
                                 (addr_arr[gi] == tag_reg[gi]) & ~downloading;
            assign pending[gi] = cs_vec[gi] & ~ok_vec[gi];
        end
    endgenerate

    assign slot0_ok   = ok_vec[0];
    assign slot1_ok   = ok_vec[1];
    assign slot2_ok   = ok_vec[2];
    assign slot3_ok   = ok_vec[3];
    assign slot0_data = dat_reg[0];
    assign slot1_data = dat_reg[1];
    assign slot2_data = dat_reg[2];
    assign slot3_data = dat_reg[3];
    assign mem_req    = mem_req_reg;
    assign mem_addr   = mem_addr_reg;

    // Round-robin search: first pending slot starting after the last grant.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (!win_found && pending[last_reg + 2'(k)]) begin
                win_found = 1'b1;
                win_idx   = last_reg + 2'(k);
            end
        end
    end

    // Next-state logic for the single-outstanding memory transaction.
    always_comb begin
        state_next    = state_reg;
        mem_req_next  = mem_req_reg;
        mem_addr_next = mem_addr_reg;
        last_next     = last_reg;
        sel_next      = sel_reg;
        req_tag_next  = req_tag_reg;
        fill          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!downloading && win_found) begin
                    sel_next      = win_idx;
                    req_tag_next  = addr_arr[win_idx];
                    mem_addr_next = offset_arr[win_idx] + {4'd0, addr_arr[win_idx]};
                    mem_req_next  = 1'b1;
                    last_next     = win_idx;
                    state_next    = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                // a rdy coinciding with the grant belongs to nothing yet
                if (mem_gnt) begin
                    mem_req_next = 1'b0;
                    state_next   = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (mem_rdy) begin
                    fill       = ~downloading;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= '0;
            last_reg     <= 2'd3;
            sel_reg      <= 2'd0;
            req_tag_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            mem_req_reg  <= mem_req_next;
            mem_addr_reg <= mem_addr_next;
            last_reg     <= last_next;
            sel_reg      <= sel_next;
            req_tag_reg  <= req_tag_next;
        end
    end

    // Cache entries: flushed while downloading, filled with the latched tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                valid_reg[i] <= 1'b0;
                tag_reg[i]   <= '0;
                dat_reg[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (downloading) begin
                    valid_reg[i] <= 1'b0;
                end else if (fill && sel_reg == 2'(i)) begin
                    valid_reg[i] <= 1'b1;
                    tag_reg[i]   <= req_tag_reg;
                    dat_reg[i]   <= mem_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_jtcop_gfx_romarb.sv
// Self-checking bench for jtcop_gfx_romarb: directed scenarios plus
// randomized rounds checked against a transaction-level cache model.
module tb_jtcop_gfx_romarb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst2_n = 1'b0;
    logic        downloading = 1'b0;
    logic        cs [4];
    logic [17:0] addr [4];
    logic [31:0] data [4];
    logic        ok [4];
    logic [31:0] data2 [4];
    logic        ok2 [4];
    logic        mem_req, mem_req2;
    logic [21:0] mem_addr, mem_addr2;
    logic        mem_gnt, mem_rdy;
    logic [31:0] mem_data;
    logic        mem_gnt2 = 1'b0;
    logic        mem_rdy2 = 1'b0;

    // memory side: either the automatic responder or direct test control
    bit          auto_mem = 1'b0;
    logic        r_gnt = 1'b0, r_rdy = 1'b0;
    logic [31:0] r_data = '0;
    logic        t_gnt = 1'b0, t_rdy = 1'b0;
    logic [31:0] t_data = '0;
    int          gnt_wait = 0, rdy_wait = 0;
    logic [21:0] log_q [$];
    int          proto_viol = 0;

    int tests_run = 0;
    int tests_failed = 0;

    // transaction-level cache model
    bit          m_valid [4];
    logic [17:0] m_tag [4];
    logic [31:0] m_dat [4];
    int          m_last;

    assign mem_gnt  = auto_mem ? r_gnt  : t_gnt;
    assign mem_rdy  = auto_mem ? r_rdy  : t_rdy;
    assign mem_data = auto_mem ? r_data : t_data;

    jtcop_gfx_romarb dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .slot0_cs(cs[0]), .slot0_addr(addr[0]), .slot0_data(data[0]), .slot0_ok(ok[0]),
        .slot1_cs(cs[1]), .slot1_addr(addr[1]), .slot1_data(data[1]), .slot1_ok(ok[1]),
        .slot2_cs(cs[2]), .slot2_addr(addr[2]), .slot2_data(data[2]), .slot2_ok(ok[2]),
        .slot3_cs(cs[3]), .slot3_addr(addr[3]), .slot3_data(data[3]), .slot3_ok(ok[3]),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rdy(mem_rdy), .mem_data(mem_data)
    );

    jtcop_gfx_romarb #(.OFFSET3(22'h3C0001)) dut2 (
        .clk(clk), .rst_n(rst2_n), .downloading(downloading),
        .slot0_cs(cs[0]), .slot0_addr(addr[0]), .slot0_data(data2[0]), .slot0_ok(ok2[0]),
        .slot1_cs(cs[1]), .slot1_addr(addr[1]), .slot1_data(data2[1]), .slot1_ok(ok2[1]),
        .slot2_cs(cs[2]), .slot2_addr(addr[2]), .slot2_data(data2[2]), .slot2_ok(ok2[2]),
        .slot3_cs(cs[3]), .slot3_addr(addr[3]), .slot3_data(data2[3]), .slot3_ok(ok2[3]),
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_gnt(mem_gnt2),
        .mem_rdy(mem_rdy2), .mem_data(32'h0)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [21:0] a);
        return {a[9:0], a} ^ 32'hA5C3_0F1E;
    endfunction

    function automatic logic [21:0] off(input int s);
        case (s)
            0: return 22'h00000;
            1: return 22'h40000;
            2: return 22'h80000;
            default: return 22'hC0000;
        endcase
    endfunction

    // Automatic memory responder with configurable grant/data latency.
    initial begin : responder
        logic [21:0] a;
        forever begin
            @(negedge clk);
            if (auto_mem && mem_req) begin
                a = mem_addr;
                log_q.push_back(a);
                for (int i = 0; i < gnt_wait; i++) begin
                    @(negedge clk);
                    if (!mem_req || mem_addr !== a) proto_viol++;
                end
                r_gnt = 1'b1;
                @(negedge clk);
                r_gnt = 1'b0;
                if (mem_req) proto_viol++;
                for (int i = 0; i < rdy_wait; i++) @(negedge clk);
                r_rdy  = 1'b1;
                r_data = mem_fn(a);
                $display("[TB] txn addr=%06h data=%08h", a, r_data);
                @(negedge clk);
                r_rdy = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        auto_mem = 1'b0;
        rst_n = 1'b0;
        downloading = 1'b0;
        t_gnt = 1'b0; t_rdy = 1'b0; t_data = '0;
        for (int i = 0; i < 4; i++) begin
            cs[i] = 1'b0; addr[i] = '0;
            m_valid[i] = 1'b0; m_tag[i] = '0; m_dat[i] = '0;
        end
        m_last = 3;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_req(output bit got);
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        got = mem_req;
    endtask

    task automatic wait_quiet(output bit done);
        int quiet = 0;
        bit all_ok;
        for (int i = 0; i < 400 && quiet < 3; i++) begin
            @(negedge clk);
            #1;
            all_ok = 1'b1;
            for (int s = 0; s < 4; s++) if (cs[s] && !ok[s]) all_ok = 1'b0;
            if (!mem_req && all_ok) quiet++; else quiet = 0;
        end
        done = (quiet >= 3);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin cs[i] = 1'b1; addr[i] = '0; end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req got=%0b exp=0", mem_req); end
        tests_run++; if (mem_addr !== 22'h0) begin tests_failed++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (ok[i] !== 1'b0) begin tests_failed++; $display("FAIL reset_ok%0d got=%0b exp=0", i, ok[i]); end
            tests_run++; if (data[i] !== 32'h0) begin tests_failed++; $display("FAIL reset_data%0d got=%h exp=0", i, data[i]); end
        end
    endtask

    task automatic test_single_miss();
        int extra = 0;
        do_reset();
        cs[0] = 1'b1; addr[0] = 18'h00010;
        #1;
        tests_run++; if (ok[0] !== 1'b0) begin tests_failed++; $display("FAIL miss_ok0_c0 got=%0b exp=0", ok[0]); end
        @(negedge clk);
        tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL miss_req_c1 got=%0b exp=1", mem_req); end
        tests_run++; if (mem_addr !== 22'h00010) begin tests_failed++; $display("FAIL miss_addr got=%h exp=000010", mem_addr); end
        t_gnt = 1'b1;
        @(negedge clk);
        t_gnt = 1'b0;
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL miss_req_drop got=%0b exp=0", mem_req); end
        t_rdy = 1'b1; t_data = 32'hDEADBEEF;
        @(negedge clk);
        t_rdy = 1'b0;
        tests_run++; if (ok[0] !== 1'b1) begin tests_failed++; $display("FAIL miss_ok0_c3 got=%0b exp=1", ok[0]); end
        tests_run++; if (data[0] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL miss_data0 got=%h exp=deadbeef", data[0]); end
        repeat (4) begin @(negedge clk); if (mem_req !== 1'b0) extra++; end
        tests_run++; if (extra != 0) begin tests_failed++; $display("FAIL hit_no_req got=%0d exp=0 request cycles", extra); end
        cs[0] = 1'b0;
        #1;
        tests_run++; if (ok[0] !== 1'b0) begin tests_failed++; $display("FAIL hit_cs_low got=%0b exp=0", ok[0]); end
        @(negedge clk);
        cs[0] = 1'b1;
        #1;
        tests_run++; if (ok[0] !== 1'b1) begin tests_failed++; $display("FAIL hit_same_cycle got=%0b exp=1", ok[0]); end
    endtask

    task automatic test_offset();
        bit done;
        do_reset();
        rst2_n = 1'b1;
        cs[3] = 1'b1; addr[3] = 18'h3FFFF;
        @(negedge clk);
        tests_run++; if (mem_addr !== 22'h0FFFFF) begin tests_failed++; $display("FAIL offset_sum got=%h exp=0fffff", mem_addr); end
        tests_run++; if (mem_req2 !== 1'b1 || mem_addr2 !== 22'h000000) begin tests_failed++; $display("FAIL offset_wrap got=%0b/%h exp=1/000000", mem_req2, mem_addr2); end
        auto_mem = 1'b1;
        wait_quiet(done);
        tests_run++; if (!done || data[3] !== mem_fn(22'h0FFFFF)) begin tests_failed++; $display("FAIL offset_fill got=%h exp=%h", data[3], mem_fn(22'h0FFFFF)); end
        auto_mem = 1'b0;
        rst2_n = 1'b0;
    endtask

    task automatic test_round_robin();
        bit done;
        int order [5] = '{0, 1, 2, 3, 1};
        logic [17:0] a1_new = 18'h2ABCD;
        logic [21:0] exp_a;
        do_reset();
        gnt_wait = 1; rdy_wait = 1; proto_viol = 0;
        log_q.delete();
        for (int i = 0; i < 4; i++) begin cs[i] = 1'b1; addr[i] = 18'(i * 18'h111 + 5); end
        auto_mem = 1'b1;
        for (int i = 0; i < 100 && log_q.size() < 2; i++) @(negedge clk);
        addr[1] = a1_new;
        wait_quiet(done);
        tests_run++; if (!done) begin tests_failed++; $display("FAIL rr_timeout got=busy exp=idle"); end
        tests_run++; if (log_q.size() != 5) begin tests_failed++; $display("FAIL rr_count got=%0d exp=5", log_q.size()); end
        for (int j = 0; j < 5 && j < log_q.size(); j++) begin
            exp_a = off(order[j]) + {4'd0, (j == 4) ? a1_new : 18'(order[j] * 18'h111 + 5)};
            tests_run++; if (log_q[j] !== exp_a) begin tests_failed++; $display("FAIL rr_grant%0d got=%h exp=%h", j, log_q[j], exp_a); end
        end
        tests_run++; if (proto_viol != 0) begin tests_failed++; $display("FAIL rr_protocol got=%0d exp=0 violations", proto_viol); end
        tests_run++; if (data[1] !== mem_fn(off(1) + {4'd0, a1_new})) begin tests_failed++; $display("FAIL rr_data1 got=%h exp=%h", data[1], mem_fn(off(1) + {4'd0, a1_new})); end
        auto_mem = 1'b0;
    endtask

    task automatic test_random();
        bit done;
        bit pend [4];
        int exp_q [$];
        logic [21:0] exp_a;
        do_reset();
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            exp_q.delete();
            for (int i = 0; i < 4; i++) begin
                cs[i] = ($urandom_range(3) != 0);
                if ($urandom_range(1) == 1) addr[i] = 18'($urandom_range(15));
                pend[i] = cs[i] && !(m_valid[i] && m_tag[i] == addr[i]);
            end
            for (int k = 1; k <= 4; k++) if (pend[(m_last + k) % 4]) exp_q.push_back((m_last + k) % 4);
            gnt_wait = $urandom_range(3); rdy_wait = $urandom_range(3);
            log_q.delete();
            auto_mem = 1'b1;
            wait_quiet(done);
            tests_run++; if (!done || log_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL rand%0d_count got=%0d exp=%0d done=%0b", r, log_q.size(), exp_q.size(), done); end
            for (int j = 0; j < exp_q.size() && j < log_q.size(); j++) begin
                exp_a = off(exp_q[j]) + {4'd0, addr[exp_q[j]]};
                tests_run++; if (log_q[j] !== exp_a) begin tests_failed++; $display("FAIL rand%0d_grant%0d got=%h exp=%h", r, j, log_q[j], exp_a); end
            end
            foreach (exp_q[j]) begin
                m_valid[exp_q[j]] = 1'b1;
                m_tag[exp_q[j]]   = addr[exp_q[j]];
                m_dat[exp_q[j]]   = mem_fn(off(exp_q[j]) + {4'd0, addr[exp_q[j]]});
                m_last = exp_q[j];
            end
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (ok[i] !== (cs[i] && m_valid[i] && m_tag[i] == addr[i]) || data[i] !== m_dat[i]) begin
                    tests_failed++;
                    $display("FAIL rand%0d_slot%0d got=%0b/%h exp=%0b/%h", r, i, ok[i], data[i], cs[i] && m_valid[i] && m_tag[i] == addr[i], m_dat[i]);
                end
            end
        end
        auto_mem = 1'b0;
    endtask

    task automatic test_stale_and_dual();
        bit got;
        do_reset();
        cs[2] = 1'b1; addr[2] = 18'h100;
        wait_req(got);
        tests_run++; if (!got || mem_addr !== off(2) + 22'h100) begin tests_failed++; $display("FAIL stale_req1 got=%0b/%h exp=1/%h", got, mem_addr, off(2) + 22'h100); end
        t_gnt = 1'b1; t_rdy = 1'b1; t_data = 32'hBAD0BAD0;
        @(negedge clk);
        t_gnt = 1'b0; t_rdy = 1'b0;
        addr[2] = 18'h104;
        #1;
        tests_run++; if (ok[2] !== 1'b0 || data[2] !== 32'h0) begin tests_failed++; $display("FAIL dual_gnt_rdy got=%0b/%h exp=0/00000000", ok[2], data[2]); end
        @(negedge clk);
        t_rdy = 1'b1; t_data = 32'h11112222;
        @(negedge clk);
        t_rdy = 1'b0;
        #1;
        tests_run++; if (ok[2] !== 1'b0) begin tests_failed++; $display("FAIL stale_ok_low got=%0b exp=0", ok[2]); end
        addr[2] = 18'h100;
        #1;
        tests_run++; if (ok[2] !== 1'b1 || data[2] !== 32'h11112222) begin tests_failed++; $display("FAIL stale_tag got=%0b/%h exp=1/11112222", ok[2], data[2]); end
        @(negedge clk);
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL stale_no_req got=%0b exp=0", mem_req); end
        addr[2] = 18'h104;
        @(negedge clk);
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== off(2) + 22'h104) begin tests_failed++; $display("FAIL stale_req2 got=%0b/%h exp=1/%h", mem_req, mem_addr, off(2) + 22'h104); end
        t_gnt = 1'b1;
        @(negedge clk);
        t_gnt = 1'b0; t_rdy = 1'b1; t_data = 32'h33334444;
        @(negedge clk);
        t_rdy = 1'b0;
        #1;
        tests_run++; if (ok[2] !== 1'b1 || data[2] !== 32'h33334444) begin tests_failed++; $display("FAIL stale_refill got=%0b/%h exp=1/33334444", ok[2], data[2]); end
    endtask

    task automatic test_download();
        bit done, got;
        int bad = 0;
        do_reset();
        gnt_wait = 0; rdy_wait = 0;
        cs[1] = 1'b1; addr[1] = 18'h22;
        auto_mem = 1'b1;
        wait_quiet(done);
        auto_mem = 1'b0;
        tests_run++; if (!done || ok[1] !== 1'b1) begin tests_failed++; $display("FAIL dl_prefill got=%0b exp=1", ok[1]); end
        cs[0] = 1'b1; addr[0] = 18'h33;
        wait_req(got);
        downloading = 1'b1;
        #1;
        tests_run++; if (!got || ok[1] !== 1'b0) begin tests_failed++; $display("FAIL dl_ok_clear got=%0b exp=0", ok[1]); end
        repeat (2) @(negedge clk);
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== off(0) + 22'h33) begin tests_failed++; $display("FAIL dl_req_hold got=%0b/%h exp=1/%h", mem_req, mem_addr, off(0) + 22'h33); end
        t_gnt = 1'b1;
        @(negedge clk);
        t_gnt = 1'b0; t_rdy = 1'b1; t_data = 32'hCAFEF00D;
        @(negedge clk);
        t_rdy = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mem_req !== 1'b0) bad++;
            for (int i = 0; i < 4; i++) if (ok[i] !== 1'b0) bad++;
        end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL dl_quiet got=%0d exp=0 violations", bad); end
        tests_run++; if (data[0] !== 32'h0) begin tests_failed++; $display("FAIL dl_discard got=%h exp=00000000", data[0]); end
        downloading = 1'b0;
        @(negedge clk);
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== off(1) + 22'h22) begin tests_failed++; $display("FAIL dl_refetch got=%0b/%h exp=1/%h", mem_req, mem_addr, off(1) + 22'h22); end
        auto_mem = 1'b1;
        wait_quiet(done);
        auto_mem = 1'b0;
        tests_run++; if (!done || data[0] !== mem_fn(off(0) + 22'h33)) begin tests_failed++; $display("FAIL dl_after got=%h exp=%h", data[0], mem_fn(off(0) + 22'h33)); end
    endtask

    task automatic test_reset_mid();
        bit done, got;
        do_reset();
        gnt_wait = 0; rdy_wait = 0;
        cs[0] = 1'b1; addr[0] = 18'h44;
        auto_mem = 1'b1;
        wait_quiet(done);
        auto_mem = 1'b0;
        cs[3] = 1'b1; addr[3] = 18'h55;
        wait_req(got);
        t_gnt = 1'b1;
        @(negedge clk);
        t_gnt = 1'b0;
        tests_run++; if (!got || !done || ok[0] !== 1'b1) begin tests_failed++; $display("FAIL rmid_pre got=%0b exp=1", ok[0]); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (mem_req !== 1'b0 || ok[0] !== 1'b0 || data[0] !== 32'h0) begin tests_failed++; $display("FAIL rmid_async got=%0b/%0b/%h exp=0/0/00000000", mem_req, ok[0], data[0]); end
        @(negedge clk);
        cs[0] = 1'b0; cs[3] = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        t_rdy = 1'b1; t_data = 32'h0000BEEF;
        @(negedge clk);
        t_rdy = 1'b0;
        cs[3] = 1'b1;
        #1;
        tests_run++; if (ok[3] !== 1'b0 || data[3] !== 32'h0) begin tests_failed++; $display("FAIL rmid_ignore got=%0b/%h exp=0/00000000", ok[3], data[3]); end
        @(negedge clk);
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== off(3) + 22'h55) begin tests_failed++; $display("FAIL rmid_refetch got=%0b/%h exp=1/%h", mem_req, mem_addr, off(3) + 22'h55); end
        auto_mem = 1'b1;
        wait_quiet(done);
        auto_mem = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin cs[i] = 1'b0; addr[i] = '0; end
        test_reset();
        test_single_miss();
        test_offset();
        test_round_robin();
        test_random();
        test_stale_and_dual();
        test_download();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
